lock_sequencer: RTL
===================

Name: lock_sequencer

Overview:
Sequencer for the combination-lock datapath. It edge-detects the ENTER key and collects a multi-digit code from the switches one digit per press. It compares the entry against a programmable stored code, counts failed attempts and enforces a timed lockout. It sits between the board top level (keys, switches, LEDs, HEX) and the display logic, replacing ad-hoc MATCH/save wiring with one controlled FSM.

Parameters:
DIGITS, 4, number of digits per code
DIGIT_W, 4, bits per digit
RESET_CODE, 16'h1234, code after reset (DIGITS*DIGIT_W bits); digit 0 is the MSB nibble
MAX_TRIES, 3, failed attempts allowed before lockout
LOCKOUT_CYCLES, 16, lockout duration in clk cycles (board top overrides to about 5 s)

Ports:
clk  in  1  system clock
RESET  in  1  synchronous active-high reset
enter  in  1  ENTER level, 1 = pressed (top inverts KEY)
digit  in  DIGIT_W  digit value from switches
prog  in  1  when 1, a press in OPEN starts reprogramming
unlocked  out  1  high in OPEN
locked_out  out  1  high in LOCKOUT
err  out  1  one-cycle pulse on a failed check
prog_done  out  1  one-cycle pulse when the new code is stored
digit_idx  out  clog2(DIGITS)  index of the next digit expected
tries_left  out  clog2(MAX_TRIES+1)  remaining attempts
state  out  3  current FSM state (lock_pkg encoding), for debug LEDs

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (RESET).
- Reset values:
  - state = ENTRY; code_reg = RESET_CODE; digit_idx = 0; tries_left = MAX_TRIES.
  - mismatch = 0; lockout counter = 0.
  - unlocked, locked_out, err, prog_done all 0.
  - enter_q = 1, so a key held through reset does not produce a press.
- Press detection: enter_q registers enter every cycle; press = enter & ~enter_q. A press is exactly one cycle. Holding the key gives one press.
- States: ENTRY, CHECK, OPEN, PROGRAM, LOCKOUT.
- ENTRY:
  - On press, compare digit with code digit[digit_idx] and set mismatch |= (digit != code digit).
  - If digit_idx == DIGITS-1: digit_idx <= 0 and go to CHECK next cycle. Otherwise digit_idx increments.
- CHECK lasts exactly 1 cycle. Presses during CHECK are ignored. mismatch is cleared on exit.
  - mismatch == 0: go to OPEN; tries_left <= MAX_TRIES.
  - mismatch == 1 and tries_left > 1: err = 1 for this cycle; tries_left decrements; go to ENTRY.
  - mismatch == 1 and tries_left == 1: err = 1; tries_left <= 0; lockout counter <= LOCKOUT_CYCLES-1; go to LOCKOUT.
- Latency: unlocked rises 2 cycles after the clk edge that samples the final press (capture, then CHECK).
- OPEN:
  - unlocked = 1.
  - Press with prog = 0: relock, go to ENTRY.
  - Press with prog = 1: go to PROGRAM with digit_idx = 0. The digit value on that press is not stored.
- PROGRAM:
  - unlocked stays 1.
  - Each press writes digit into code_reg digit[digit_idx] and increments digit_idx.
  - On the write of index DIGITS-1: prog_done = 1 the next cycle; digit_idx <= 0; go to ENTRY.
  - The new code is effective for the very next entry.
- LOCKOUT:
  - locked_out = 1; all presses ignored.
  - The counter decrements each cycle. In the cycle it reads 0: go to ENTRY; tries_left <= MAX_TRIES; digit_idx <= 0.
  - Total dwell is LOCKOUT_CYCLES cycles.
- Outputs: all registered Moore/pulse outputs. err and prog_done are never high for more than 1 cycle.
- Reset mid-operation: any state returns to the reset values. A code programmed since the last reset is lost and code_reg reverts to RESET_CODE.
- Partial entry: no timeout. Digits persist until DIGITS presses have been made or reset occurs.
- Unused encodings of state: recover to ENTRY.

Decomposition:
- lock_pkg holds:
  - state_t enum (ENTRY=0, CHECK=1, OPEN=2, PROGRAM=3, LOCKOUT=4).
  - A localparam function for counter widths.
- Sub-module edge_detect (enter -> one-cycle press, reset value 1) is natural and reused for other keys.
- Everything else stays in lock_sequencer.

Test Plan:
All scenarios use the default parameters unless stated.
1. Reset, then presses with digit 1, 2, 3, 4 -> unlocked = 1 exactly 2 cycles after the 4th press; tries_left = 3; err never pulses.
2. Enter 1,2,3,5 -> single-cycle err, tries_left = 2, state = ENTRY. Then enter 1,2,3,4 -> unlocked = 1 and tries_left = 3.
3. Three wrong codes -> locked_out = 1 for exactly 16 cycles. Presses during lockout are ignored (digit_idx stays 0). Then ENTRY with tries_left = 3.
4. From OPEN: press with prog = 1, then 9, A, B, C -> prog_done pulse, state = ENTRY. Then 1,2,3,4 -> err. Then 9,A,B,C -> unlocked.
5. Hold enter high for 10 cycles -> digit_idx advances by exactly 1. Assert RESET after 2 digits -> digit_idx = 0; the code reverts to 16'h1234.
6. Press in the CHECK cycle, and enter held high through reset release -> no digit captured; digit_idx = 0 in both cases.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared types and sizing helpers for the combination-lock sequencer.
// The state encoding is exported on the debug LEDs, so values are fixed.
package lock_pkg;

  typedef enum logic [2:0] {
    ENTRY   = 3'd0,
    CHECK   = 3'd1,
    OPEN    = 3'd2,
    PROGRAM = 3'd3,
    LOCKOUT = 3'd4
  } state_t;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Turns a key level into a one-cycle press pulse on the rising edge.
// The history flop resets high so a key held through reset is not a press.
module edge_detect (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_lvl,
  output logic o_press
);

  logic r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_q <= 1'b1;
    else       r_q <= i_lvl;
  end

  assign o_press = i_lvl & ~r_q;

endmodule

// File: rtl/lock_sequencer.sv
// Combination-lock sequencer: collects digits on ENTER presses, checks them
// against a programmable code, counts failed tries and enforces a lockout.
module lock_sequencer
  import lock_pkg::*;
#(
  parameter int                          DIGITS         = 4,
  parameter int                          DIGIT_W        = 4,
  parameter logic [DIGITS*DIGIT_W-1:0]   RESET_CODE     = 16'h1234,
  parameter int                          MAX_TRIES      = 3,
  parameter int                          LOCKOUT_CYCLES = 16
) (
  input  logic                               clk,
  input  logic                               RESET,
  input  logic                               enter,
  input  logic [DIGIT_W-1:0]                 digit,
  input  logic                               prog,
  output logic                               unlocked,
  output logic                               locked_out,
  output logic                               err,
  output logic                               prog_done,
  output logic [cnt_w(DIGITS)-1:0]           digit_idx,
  output logic [cnt_w(MAX_TRIES+1)-1:0]      tries_left,
  output logic [2:0]                         state
);

  localparam int IW = cnt_w(DIGITS);
  localparam int TW = cnt_w(MAX_TRIES + 1);
  localparam int CW = cnt_w(LOCKOUT_CYCLES);
  localparam int CODE_W = DIGITS * DIGIT_W;

  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [TW-1:0] TRIES_MAX = TW'(MAX_TRIES);
  localparam logic [TW-1:0] TRIES_ONE = TW'(1);
  localparam logic [CW-1:0] CNT_LOAD  = CW'(LOCKOUT_CYCLES - 1);

  state_t              r_state;
  state_t              w_next;
  logic [CODE_W-1:0]   r_code;
  logic [IW-1:0]       r_idx;
  logic [TW-1:0]       r_tries;
  logic [CW-1:0]       r_cnt;
  logic                r_mismatch;
  logic                r_unlocked;
  logic                r_locked;
  logic                r_err;
  logic                r_done;
  logic                w_press;
  logic                w_err_nxt;
  logic                w_done_nxt;
  logic [DIGIT_W-1:0]  w_cur;
  logic                w_last;

  edge_detect u_enter_edge (
    .i_clk   (clk),
    .i_rst   (RESET),
    .i_lvl   (enter),
    .o_press (w_press)
  );

  // Digit 0 occupies the most significant nibble of the code.
  assign w_cur  = r_code[(DIGITS - 1 - int'(r_idx)) * DIGIT_W +: DIGIT_W];
  assign w_last = (r_idx == IDX_LAST);

  always_ff @(posedge clk) begin
    if (RESET) r_state <= ENTRY;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_err_nxt  = 1'b0;
    w_done_nxt = 1'b0;
    case (r_state)
      ENTRY:   if (w_press && w_last) w_next = CHECK;
      CHECK: begin
        if (!r_mismatch) begin
          w_next = OPEN;
        end else begin
          w_err_nxt = 1'b1;
          w_next    = (r_tries > TRIES_ONE) ? ENTRY : LOCKOUT;
        end
      end
      OPEN:    if (w_press) w_next = prog ? PROGRAM : ENTRY;
      PROGRAM: begin
        if (w_press && w_last) begin
          w_next     = ENTRY;
          w_done_nxt = 1'b1;
        end
      end
      LOCKOUT: if (r_cnt == '0) w_next = ENTRY;
      default: w_next = ENTRY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      r_code     <= RESET_CODE;
      r_idx      <= '0;
      r_tries    <= TRIES_MAX;
      r_cnt      <= '0;
      r_mismatch <= 1'b0;
      r_unlocked <= 1'b0;
      r_locked   <= 1'b0;
      r_err      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      // Flag outputs track the state being entered so they line up with it.
      r_unlocked <= (w_next == OPEN) || (w_next == PROGRAM);
      r_locked   <= (w_next == LOCKOUT);
      r_err      <= w_err_nxt;
      r_done     <= w_done_nxt;
      case (r_state)
        ENTRY: begin
          if (w_press) begin
            r_mismatch <= r_mismatch | (digit != w_cur);
            r_idx      <= w_last ? '0 : r_idx + 1'b1;
          end
        end
        CHECK: begin
          r_mismatch <= 1'b0;
          if (!r_mismatch) begin
            r_tries <= TRIES_MAX;
          end else if (r_tries > TRIES_ONE) begin
            r_tries <= r_tries - 1'b1;
          end else begin
            r_tries <= '0;
            r_cnt   <= CNT_LOAD;
          end
        end
        OPEN: begin
          if (w_press && prog) r_idx <= '0;
        end
        PROGRAM: begin
          if (w_press) begin
            r_code[(DIGITS - 1 - int'(r_idx)) * DIGIT_W +: DIGIT_W] <= digit;
            r_idx <= w_last ? '0 : r_idx + 1'b1;
          end
        end
        LOCKOUT: begin
          if (r_cnt == '0) begin
            r_tries <= TRIES_MAX;
            r_idx   <= '0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_idx      <= '0;
          r_mismatch <= 1'b0;
        end
      endcase
    end
  end

  assign unlocked   = r_unlocked;
  assign locked_out = r_locked;
  assign err        = r_err;
  assign prog_done  = r_done;
  assign digit_idx  = r_idx;
  assign tries_left = r_tries;
  assign state      = r_state;

endmodule
